// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: opcode class ranges, class enum and operand sequencer states.
package cpu_pkg;

  localparam logic [4:0] TWO_LO   = 5'h04;
  localparam logic [4:0] TWO_HI   = 5'h0C;
  localparam logic [4:0] ONE_HI   = 5'h13;
  localparam logic [4:0] ONE_EXCL = 5'h0E;

  typedef enum logic [1:0] {
    NONE,
    ONE,
    TWO
  } op_class_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH1,
    LOAD1,
    FETCH2,
    LOAD2,
    DONE
  } state_t;

endpackage

// File: rtl/operand_class.sv
// Combinational opcode-to-operand-count classifier, shared by the operand sender and receiver.
module operand_class
  import cpu_pkg::*;
(
  input  logic [4:0] opcode,
  output op_class_t  op_class
);

  always_comb begin
    op_class = NONE;
    if (opcode >= TWO_LO && opcode <= TWO_HI) begin
      op_class = TWO;
    end else if (opcode > TWO_HI && opcode <= ONE_HI && opcode != ONE_EXCL) begin
      op_class = ONE;
    end
  end

endmodule

// File: rtl/operand_sequencer.sv
// Operand-load sequencer: fetches 0-2 operand bytes from a synchronous-read memory and strobes them out.
// Build option OPSEQ_PREFETCH_EN overlaps the second read with the first load.
module operand_sequencer
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [4:0]        opcode,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic [4:0]        op_out,
  output logic [DATA_W-1:0] dout,
  output logic              load,
  output logic              busy,
  output logic              done
);

  state_t            state_q, state_d;
  op_class_t         cls_q, cls_d;
  op_class_t         op_class;
  logic [4:0]        op_out_q, op_out_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [ADDR_W-1:0] addr_next;

  operand_class u_class (
    .opcode   (opcode),
    .op_class (op_class)
  );

  assign addr_next = addr_q + ADDR_W'(1);

  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    op_out_d   = op_out_q;
    addr_d     = addr_q;
    mem_addr_d = mem_addr_q;
    dout_d     = dout_q;
    mem_rd     = 1'b0;
    load       = 1'b0;
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_out_d = opcode;
          addr_d   = base_addr;
          cls_d    = op_class;
          if (op_class == NONE) begin
            state_d = DONE;
          end else begin
            state_d    = FETCH1;
            mem_addr_d = base_addr;
          end
        end
      end
      FETCH1: begin
        mem_rd  = 1'b1;
        state_d = LOAD1;
`ifdef OPSEQ_PREFETCH_EN
        // Address for the overlapped second read must be in place during LOAD1.
        if (cls_q == TWO) mem_addr_d = addr_next;
`endif
      end
      LOAD1: begin
        load   = 1'b1;
        dout_d = mem_data;
`ifdef OPSEQ_PREFETCH_EN
        if (cls_q == TWO) begin
          mem_rd  = 1'b1;
          state_d = LOAD2;
        end else begin
          state_d = DONE;
        end
`else
        if (cls_q == TWO) begin
          state_d    = FETCH2;
          mem_addr_d = addr_next;
        end else begin
          state_d = DONE;
        end
`endif
      end
      FETCH2: begin
        mem_rd  = 1'b1;
        state_d = LOAD2;
      end
      LOAD2: begin
        load    = 1'b1;
        dout_d  = mem_data;
        state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      cls_q      <= NONE;
      op_out_q   <= '0;
      addr_q     <= '0;
      mem_addr_q <= '0;
      dout_q     <= '0;
    end else begin
      state_q    <= state_d;
      cls_q      <= cls_d;
      op_out_q   <= op_out_d;
      addr_q     <= addr_d;
      mem_addr_q <= mem_addr_d;
      dout_q     <= dout_d;
    end
  end

  // Read data arrives in the load cycle itself, so it bypasses the hold register while load is high.
  assign dout     = load ? mem_data : dout_q;
  assign mem_addr = mem_addr_q;
  assign op_out   = op_out_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_operand_sequencer.sv
// Bench for operand_sequencer: directed scenarios plus random transactions against a cycle-table model.
module tb_operand_sequencer;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start;
  logic [4:0] opcode;
  logic [7:0] base_addr;
  logic       mem_rd;
  logic [7:0] mem_addr;
  logic [7:0] mem_data = 8'h00;
  logic [4:0] op_out;
  logic [7:0] dout;
  logic       load;
  logic       busy;
  logic       done;

  logic [7:0] mem [256];
  logic [7:0] last_dout;
  int checks   = 0;
  int failures = 0;

  operand_sequencer #(.DATA_W(8), .ADDR_W(8)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .opcode    (opcode),
    .base_addr (base_addr),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .op_out    (op_out),
    .dout      (dout),
    .load      (load),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd) mem_data <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".mem_rd"},   32'(mem_rd),   32'h0);
    chk({tag, ".mem_addr"}, 32'(mem_addr), 32'h0);
    chk({tag, ".op_out"},   32'(op_out),   32'h0);
    chk({tag, ".dout"},     32'(dout),     32'h0);
    chk({tag, ".load"},     32'(load),     32'h0);
    chk({tag, ".busy"},     32'(busy),     32'h0);
    chk({tag, ".done"},     32'(done),     32'h0);
  endtask

  // Issue one start and check every cycle up to the IDLE cycle after done.
  // inject > 0 pulses start with a different command in that cycle; it must be ignored.
  task automatic run_txn(input logic [4:0] opc, input logic [7:0] base, input int inject);
    int n, lat, k;
    int rd_cyc [2];
    int ld_cyc [2];
    logic [7:0] addr [2];
    bit exp_rd, exp_ld;
    logic [7:0] exp_addr, exp_byte;
    string t;
    if (opc >= 5'd4 && opc <= 5'd12) n = 2;
    else if (opc >= 5'd13 && opc <= 5'd19 && opc != 5'd14) n = 1;
    else n = 0;
    for (int i = 0; i < 2; i++) begin
      addr[i] = base + 8'(i);
`ifdef OPSEQ_PREFETCH_EN
      rd_cyc[i] = 1 + i;
      ld_cyc[i] = 2 + i;
`else
      rd_cyc[i] = 1 + 2 * i;
      ld_cyc[i] = 2 + 2 * i;
`endif
    end
    if (n == 0) lat = 1;
    else lat = ld_cyc[n-1] + 1;

    @(negedge clk);
    start = 1'b1; opcode = opc; base_addr = base;
    @(posedge clk);
    for (k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      if (k == inject) begin
        start = 1'b1; opcode = ~opc; base_addr = ~base;
      end else begin
        start = 1'b0;
      end
      exp_rd = 0; exp_ld = 0; exp_addr = 8'h00; exp_byte = last_dout;
      for (int i = 0; i < n; i++) begin
        if (rd_cyc[i] == k) begin exp_rd = 1; exp_addr = addr[i]; end
        if (ld_cyc[i] == k) begin exp_ld = 1; exp_byte = mem[addr[i]]; end
      end
      t = $sformatf("op%02h@%02h.c%0d", opc, base, k);
      chk({t, ".mem_rd"}, 32'(mem_rd), 32'(exp_rd));
      if (exp_rd) chk({t, ".mem_addr"}, 32'(mem_addr), 32'(exp_addr));
      chk({t, ".load"}, 32'(load), 32'(exp_ld));
      chk({t, ".dout"}, 32'(dout), 32'(exp_byte));
      chk({t, ".done"}, 32'(done), 32'(k == lat));
      chk({t, ".busy"}, 32'(busy), 32'(k <= lat));
      chk({t, ".op_out"}, 32'(op_out), 32'(opc));
      last_dout = exp_byte;
    end
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; opcode = 5'h00; base_addr = 8'h00;
    last_dout = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h10] = 8'hAA; mem[8'h11] = 8'h55; mem[8'h20] = 8'h3C;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rstn = 1'b1;

    run_txn(5'h05, 8'h10, 0);
    run_txn(5'h10, 8'h20, 0);
    run_txn(5'h0E, 8'h30, 0);
    run_txn(5'h01, 8'h40, 0);
    run_txn(5'h0C, 8'hFF, 0);
    run_txn(5'h05, 8'h10, 2);
    run_txn(5'h13, 8'h7F, 0);

    // Reset dropped in cycle 3 of a two-operand transaction.
    @(negedge clk);
    start = 1'b1; opcode = 5'h05; base_addr = 8'h10;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk_all_zero("midreset");
    last_dout = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk); rstn = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("postreset.c%0d.load", k), 32'(load), 32'h0);
      chk($sformatf("postreset.c%0d.done", k), 32'(done), 32'h0);
      chk($sformatf("postreset.c%0d.busy", k), 32'(busy), 32'h0);
    end

    // start held high: back-to-back NONE transactions.
    start = 1'b1; opcode = 5'h01; base_addr = 8'h00;
    @(posedge clk);
    @(negedge clk); chk("held.c1.done", 32'(done), 32'h1);
    @(negedge clk); chk("held.c2.busy", 32'(busy), 32'h0);
    @(negedge clk); chk("held.c3.done", 32'(done), 32'h1);
    start = 1'b0;
    @(negedge clk); chk("held.c4.busy", 32'(busy), 32'h0);
    chk("held.c4.done", 32'(done), 32'h0);

    for (int r = 0; r < 40; r++) begin
      run_txn(5'($urandom_range(0, 31)), 8'($urandom), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
